// File: rtl/codes_pkg.sv
// ============================================================================
// Module      : codes_pkg
// Description : Shared ALU operation codes, RV64 opcode constants and the
//               decoded ID/EX control bundle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package codes_pkg;

    localparam int DATA_WIDTH = 64;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000
    } alu_control;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Control half of the issue register; operands and immediate are kept
    // beside it so they can follow the DATA_WIDTH parameter.
    typedef struct packed {
        alu_control control;
        logic [4:0] rd;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
    } decoded_t;

    localparam decoded_t DECODED_RESET = '{
        control:   ALU_ADD,
        rd:        5'd0,
        alu_src:   1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        branch:    1'b0,
        illegal:   1'b0
    };

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module      : alu_decoder
// Description : Purely combinational RV64 instruction to ALU control decode.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import codes_pkg::*;
#(
    parameter int DATA_WIDTH  = codes_pkg::DATA_WIDTH,
    parameter int INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output decoded_t               dec,
    output logic [DATA_WIDTH-1:0]  imm
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] i_imm;
    logic [DATA_WIDTH-1:0] s_imm;
    logic [DATA_WIDTH-1:0] b_imm;
    logic                  unused_rs1;

    assign opcode     = instr[6:0];
    assign rd         = instr[11:7];
    assign funct3     = instr[14:12];
    assign funct7     = instr[31:25];
    assign unused_rs1 = ^instr[19:15];

    assign i_imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign s_imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};

    logic                  legal;
    alu_control            op;
    logic                  src;
    logic                  rw;
    logic                  mr;
    logic                  mw;
    logic                  br;
    logic [DATA_WIDTH-1:0] imm_sel;

    always_comb begin
        legal   = 1'b0;
        op      = ALU_ADD;
        src     = 1'b0;
        rw      = 1'b0;
        mr      = 1'b0;
        mw      = 1'b0;
        br      = 1'b0;
        imm_sel = '0;
        case (opcode)
            OP_R: begin
                rw = 1'b1;
                if (funct7 == F7_ZERO) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  op = ALU_ADD;
                        3'b111:  op = ALU_AND;
                        3'b110:  op = ALU_OR;
                        3'b010:  op = ALU_SLT;
                        3'b011:  op = ALU_SLTU;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal = 1'b1;
                    op    = ALU_SUB;
                end
            end
            OP_IMM: begin
                legal   = 1'b1;
                rw      = 1'b1;
                src     = 1'b1;
                imm_sel = i_imm;
                case (funct3)
                    3'b000:  op = ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                legal   = (funct3 == 3'b011);
                src     = 1'b1;
                mr      = 1'b1;
                rw      = 1'b1;
                imm_sel = i_imm;
            end
            OP_STORE: begin
                legal   = (funct3 == 3'b011);
                src     = 1'b1;
                mw      = 1'b1;
                imm_sel = s_imm;
            end
            OP_BRANCH: begin
                legal   = (funct3 == 3'b000) || (funct3 == 3'b001);
                op      = ALU_SUB;
                br      = 1'b1;
                imm_sel = b_imm;
            end
            default: ;
        endcase

        // Illegal encodings still issue so EX can trap, but with no side effects.
        dec         = DECODED_RESET;
        dec.rd      = rd;
        dec.illegal = !legal;
        imm         = '0;
        if (legal) begin
            dec.control   = op;
            dec.alu_src   = src;
            dec.reg_write = rw && (rd != 5'd0);
            dec.mem_read  = mr;
            dec.mem_write = mw;
            dec.branch    = br;
            imm           = imm_sel;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_alu_issue.sv
// ============================================================================
// Module      : id_ex_alu_issue
// Description : ID/EX issue register feeding the ALU, with valid/ready
//               handshake, stall and flush.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_alu_issue
    import codes_pkg::*;
#(
    parameter int DATA_WIDTH  = codes_pkg::DATA_WIDTH,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0]  rs1_data,
    input  logic [DATA_WIDTH-1:0]  rs2_data,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  reg_1,
    output logic [DATA_WIDTH-1:0]  reg_2,
    output logic [DATA_WIDTH-1:0]  sign_extended_imm,
    output logic                   alu_src,
    output alu_control             control,
    output logic [4:0]             rd,
    output logic                   reg_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   branch,
    output logic                   illegal
);

    decoded_t              dec_new;
    logic [DATA_WIDTH-1:0] imm_new;

    alu_decoder #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_alu_decoder (
        .instr (instr),
        .dec   (dec_new),
        .imm   (imm_new)
    );

    logic                  valid_q, valid_d;
    decoded_t              dec_q, dec_d;
    logic [DATA_WIDTH-1:0] reg_1_q, reg_1_d;
    logic [DATA_WIDTH-1:0] reg_2_q, reg_2_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        reg_1_d = reg_1_q;
        reg_2_d = reg_2_q;
        imm_d   = imm_q;
        if (flush) begin
            // Data is left as-is; only the valid bit matters after a flush.
            valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d = 1'b1;
            dec_d   = dec_new;
            reg_1_d = rs1_data;
            reg_2_d = rs2_data;
            imm_d   = imm_new;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= DECODED_RESET;
            reg_1_q <= '0;
            reg_2_q <= '0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            reg_1_q <= reg_1_d;
            reg_2_q <= reg_2_d;
            imm_q   <= imm_d;
        end
    end

    assign out_valid         = valid_q;
    assign reg_1             = reg_1_q;
    assign reg_2             = reg_2_q;
    assign sign_extended_imm = imm_q;
    assign alu_src           = dec_q.alu_src;
    assign control           = dec_q.control;
    assign rd                = dec_q.rd;
    assign reg_write         = dec_q.reg_write;
    assign mem_read          = dec_q.mem_read;
    assign mem_write         = dec_q.mem_write;
    assign branch            = dec_q.branch;
    assign illegal           = dec_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_alu_issue.sv
// ============================================================================
// Module      : tb_id_ex_alu_issue
// Description : Scoreboard bench for id_ex_alu_issue with a reference decoder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_alu_issue;
    import codes_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] reg_1;
    logic [63:0] reg_2;
    logic [63:0] sign_extended_imm;
    logic        alu_src;
    alu_control  control;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;

    always #5 clk = ~clk;

    id_ex_alu_issue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .instr             (instr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .flush             (flush),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .reg_1             (reg_1),
        .reg_2             (reg_2),
        .sign_extended_imm (sign_extended_imm),
        .alu_src           (alu_src),
        .control           (control),
        .rd                (rd),
        .reg_write         (reg_write),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .branch            (branch),
        .illegal           (illegal)
    );

    typedef struct {
        logic        ill;
        alu_control  ctrl;
        logic        src, rw, mr, mw, br;
        logic [63:0] imm, r1, r2;
        logic [4:0]  rd;
        logic        chk_rd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic alu_control f3_op(input logic [2:0] f3, output logic ok);
        ok = 1'b1;
        case (f3)
            3'd0:    return ALU_ADD;
            3'd7:    return ALU_AND;
            3'd6:    return ALU_OR;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            default: begin ok = 1'b0; return ALU_ADD; end
        endcase
    endfunction

    // Reference decode straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [6:0]  opc  = ins[6:0];
        logic [2:0]  f3   = ins[14:12];
        logic [6:0]  f7   = ins[31:25];
        logic [11:0] iimm = ins[31:20];
        logic [11:0] simm = {ins[31:25], ins[11:7]};
        logic [12:0] bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        longint      v;
        logic        ok;
        alu_control  op;
        e.ill = 1'b1; e.ctrl = ALU_ADD;
        e.src = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0;
        e.imm = 64'd0; e.r1 = a; e.r2 = b; e.rd = ins[11:7]; e.chk_rd = 0;
        case (opc)
            7'h33: begin
                op = f3_op(f3, ok);
                if (f7 == 7'h00 && ok) begin
                    e.ill = 0; e.ctrl = op;
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    e.ill = 0; e.ctrl = ALU_SUB;
                end
                if (!e.ill) begin e.rw = 1; e.chk_rd = 1; end
            end
            7'h13: begin
                op = f3_op(f3, ok);
                if (ok) begin
                    v = $signed(iimm);
                    e.ill = 0; e.ctrl = op; e.src = 1; e.rw = 1; e.chk_rd = 1; e.imm = v;
                end
            end
            7'h03: if (f3 == 3'd3) begin
                v = $signed(iimm);
                e.ill = 0; e.src = 1; e.mr = 1; e.rw = 1; e.chk_rd = 1; e.imm = v;
            end
            7'h23: if (f3 == 3'd3) begin
                v = $signed(simm);
                e.ill = 0; e.src = 1; e.mw = 1; e.imm = v;
            end
            7'h63: if (f3 == 3'd0 || f3 == 3'd1) begin
                v = $signed(bimm);
                e.ill = 0; e.ctrl = ALU_SUB; e.br = 1; e.imm = v;
            end
            default: ;
        endcase
        if (e.rd == 5'd0) e.rw = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rdv;
        case ($urandom_range(0, 5))
            0:       opc = 7'h33;
            1:       opc = 7'h13;
            2:       opc = 7'h03;
            3:       opc = 7'h23;
            4:       opc = 7'h63;
            default: opc = 7'($urandom);
        endcase
        f3 = 3'($urandom_range(0, 7));
        if ((opc == 7'h03 || opc == 7'h23) && $urandom_range(0, 1) == 1) f3 = 3'd3;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        rdv = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        return {f7, 5'($urandom), 5'($urandom), f3, rdv, opc};
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        instr     = ins;
        rs1_data  = {$urandom, $urandom};
        rs2_data  = {$urandom, $urandom};
        flush     = fl;
        out_ready = rdy;
        #3;
        if (fl) q.delete();
        else if (in_valid && in_ready) q.push_back(model(instr, rs1_data, rs2_data));
    endtask

    task automatic check_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_illegal",   illegal,   0);
        chk("rst_control",   control,   ALU_ADD);
        chk("rst_alu_src",   alu_src,   0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_mem_read",  mem_read,  0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_branch",    branch,    0);
        chk("rst_reg_1",     reg_1,     0);
        chk("rst_reg_2",     reg_2,     0);
        chk("rst_imm",       sign_extended_imm, 0);
        chk("rst_rd",        rd,        0);
    endtask

    // Monitor: every live output is compared to the scoreboard head, so a
    // stalled entry is re-checked every cycle it is held.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            chk("out_valid", out_valid, q.size() != 0);
            if (out_valid && q.size() != 0) begin
                chk("illegal",   illegal,   q[0].ill);
                chk("control",   control,   q[0].ctrl);
                chk("alu_src",   alu_src,   q[0].src);
                chk("reg_write", reg_write, q[0].rw);
                chk("mem_read",  mem_read,  q[0].mr);
                chk("mem_write", mem_write, q[0].mw);
                chk("branch",    branch,    q[0].br);
                chk("reg_1",     reg_1,     q[0].r1);
                chk("reg_2",     reg_2,     q[0].r2);
                if (!q[0].ill) chk("imm", sign_extended_imm, q[0].imm);
                if (q[0].chk_rd) chk("rd", rd, q[0].rd);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 0; instr = 0; rs1_data = 0; rs2_data = 0;
        flush = 0; out_ready = 1;
        #12;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 32'h00A00093, 0, 1);
        step(1, 32'h402081B3, 0, 1);
        step(1, 32'hFFF02293, 0, 1);
        step(1, 32'hFE20BC23, 0, 1);
        step(1, 32'h00A00093, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h402081B3, 0, 0);
        step(1, 32'h402081B3, 0, 1);
        step(0, 32'h0, 0, 1);
        step(1, 32'h00A00093, 0, 0);
        step(1, 32'h402081B3, 1, 0);
        step(0, 32'h0, 0, 1);
        step(1, 32'h00000000, 0, 1);
        step(0, 32'h0, 0, 1);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

        // Reset while an instruction is held in a stall.
        step(1, 32'h00A00093, 0, 1);
        step(0, 32'h0, 0, 0);
        @(negedge clk);
        in_valid = 0;
        #3 rst_n = 1'b0;
        #1 check_reset();
        q.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 1);
        chk("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

Decode-and-issue stage that drives the ALU. It takes a fetched RV64 instruction plus register-file read data from the ID stage and decodes it into the ALU's operand and control inputs: `reg_1`, `reg_2`, `sign_extended_imm`, `alu_src` and `control`. The result is held in a single ID/EX pipeline register with a valid/ready handshake, stall and flush. It is the producer side of the ALU interface, sitting between the register file and the ALU in the pipelined CPU.

## Interface
- `DATA_WIDTH`, default `codes_pkg::DATA_WIDTH` (64): operand and immediate width.
- `INSTR_WIDTH`, default 32: instruction width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ID presents an instruction.
- `in_ready`  out  1  stage can accept; equals `!out_valid || out_ready`.
- `instr`  in  INSTR_WIDTH  raw instruction.
- `rs1_data`, `rs2_data`  in  DATA_WIDTH  register-file read data.
- `flush`  in  1  kill the held and incoming instruction.
- `out_ready`  in  1  EX accepts this cycle (de-asserted = stall).
- `out_valid`  out  1  issue register holds a live instruction.
- `reg_1`, `reg_2`  out  DATA_WIDTH  ALU operands.
- `sign_extended_imm`  out  DATA_WIDTH  immediate, sign-extended.
- `alu_src`  out  1  1 selects the immediate as operand B.
- `control`  out  `alu_control`  ALU operation.
- `rd`  out  5  destination register.
- `reg_write`  out  1  writeback enable.
- `mem_read`, `mem_write`, `branch`  out  1  downstream control.
- `illegal`  out  1  unsupported encoding.

## Operation
- **Load:** on `in_valid && in_ready` the register captures the decoded fields, with `out_valid` = 1.
- **Retire:** on `out_valid && out_ready` with no new load, `out_valid` goes to 0.
- **Stall:** while `out_valid && !out_ready`, every output holds bit-stable and `in_ready` = 0.
- **Flush:** `flush` has priority over load and hold. Next cycle `out_valid` = 0, any same-cycle incoming instruction is dropped, and data outputs are don't-care.
- **R-type (opcode 0110011):**
  - funct3 000 / funct7 0000000 → ADD; funct3 000 / funct7 0100000 → SUB.
  - funct3 111 → AND; 110 → OR; 010 → SLT; 011 → SLTU. For these four, funct7 must be 0.
  - `alu_src` = 0, `reg_write` = 1.
- **I-type ALU (0010011):** funct3 000/111/110/010/011 → ADD/AND/OR/SLT/SLTU. I-immediate, `alu_src` = 1, `reg_write` = 1.
- **Load (0000011), funct3 011:** ADD, I-immediate, `alu_src` = 1, `mem_read` = 1, `reg_write` = 1.
- **Store (0100011), funct3 011:** ADD, S-immediate, `alu_src` = 1, `mem_write` = 1, `reg_write` = 0.
- **Branch (1100011), funct3 000/001:** SUB, B-immediate (bit 0 = 0), `alu_src` = 0, `branch` = 1, `reg_write` = 0.
- **Any other encoding:** `illegal` = 1, `control` = ADD, and all enables 0. `out_valid` is still asserted so EX can trap.
- **rd = 0:** `reg_write` is forced to 0.
- **Operands:** `reg_1` = `rs1_data`, `reg_2` = `rs2_data`, passed unchanged.
- **Immediates:** sign-extended from the instruction's bit 31 to DATA_WIDTH.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid` and `out_ready`. No combinational path exists from `instr` to any output.
- **Reset (asynchronous assert, synchronous release):**
  - `out_valid` = 0 and `illegal` = 0.
  - `control` = ADD and `alu_src` = 0.
  - `reg_write`, `mem_read`, `mem_write`, `branch` = 0.
  - All data outputs and `rd` = 0.
- Reset mid-stall discards the held instruction.
- Simultaneous retire and load: the new instruction replaces the old one with no bubble.

## Structure
- `codes_pkg` gains:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - a `decoded_t` struct holding all registered output fields.
- `codes_pkg` reuses the existing `alu_control` enum and DATA_WIDTH.
- One sub-module, `alu_decoder`: purely combinational `instr` → `decoded_t`. The top level holds the register, handshake and flush.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-operation → all outputs take their reset values immediately, and `out_valid` = 0.
- **ADDI:** `instr` = 0x00A00093 (`addi x1,x0,10`) → next cycle `control` = ADD, `alu_src` = 1, imm = 10, `rd` = 1, `reg_write` = 1.
- **SUB and SLTI:**
  - `instr` = 0x402081B3 → SUB, `alu_src` = 0, `rd` = 3.
  - `instr` = 0xFFF02293 → SLT, imm = all ones (−1).
- **Store:** `instr` = 0xFE20BC23 (`sd x2,-8(x1)`) → ADD, imm = −8, `mem_write` = 1, `reg_write` = 0.
- **Stall:** load an instruction, hold `out_ready` = 0 for 3 cycles → outputs stable and `in_ready` = 0. Release → the next instruction appears the following cycle.
- **Flush and illegal:**
  - `flush` with `in_valid` = 1 → next cycle `out_valid` = 0.
  - `instr` = 0x00000000 → `illegal` = 1, `reg_write` = 0.
